rx_byte_fifo: RTL and testbench
===============================

Name: rx_byte_fifo

Overview:
Buffers bytes received by the UART RX path. It captures the parallel byte from the SIPO shift register when the RX FSM pulses done_flag, and discards frames flagged by err_flag while counting them. It presents the stored bytes to the downstream consumer over a first-word-fall-through valid/ready interface. It sits directly downstream of the RX FSM and SIPO stage and upstream of the host or user logic.

Parameters:
DATA_W, 8, width of one received byte
DEPTH, 8, number of entries; must be a power of 2, minimum 2
ADDR_W, log2(DEPTH), derived address width; not overridden by instantiator
ERR_W, 8, width of the saturating frame-error counter

Ports:
clk  in  1  system clock, rising-edge
rx_arst_n  in  1  asynchronous active-low reset
rx_rst  in  1  synchronous clear, active-high
rx_data  in  DATA_W  parallel byte from SIPO; valid in the cycle done_flag=1
done_flag  in  1  one-cycle pulse from RX FSM: good frame (stop bit = 1)
err_flag  in  1  one-cycle pulse from RX FSM: framing error (stop bit = 0)
m_data  out  DATA_W  head-of-FIFO byte; meaningful only while m_valid=1
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data this cycle
full  out  1  level == DEPTH
level  out  ADDR_W+1  number of stored bytes, 0..DEPTH
overflow  out  1  sticky; a good byte was dropped because the FIFO was full
err_cnt  out  ERR_W  saturating count of framing-error frames
clr_status  in  1  synchronous clear of overflow and err_cnt only

Behaviour:
- Reset (rx_arst_n=0, async): wptr=rptr=0, level=0, m_valid=0, full=0, overflow=0, err_cnt=0. Memory contents are don't-care; m_data is don't-care while m_valid=0.
- rx_rst=1 (sync): same effect as reset at the next edge. It overrides every push, pop and clr_status in the same cycle.
- Pointers are ADDR_W+1 bits; the MSB is the wrap bit. empty = (wptr==rptr); full = address bits equal and wrap bits differ. Pointers wrap naturally modulo 2*DEPTH.
- pop = m_valid & m_ready. rptr increments; a pop while m_valid=0 is ignored.
- push_req = done_flag & ~err_flag. If done_flag and err_flag are both 1, the error wins: no push, and err_cnt increments.
- push = push_req & (~full | pop). When full, a push is accepted in the same cycle as a pop. mem[wptr[ADDR_W-1:0]] <= rx_data and wptr increments.
- push_req & full & ~pop: the byte is dropped, pointers are unchanged, and overflow <= 1.
- level: +1 on push only, -1 on pop only, unchanged on both or neither. It is a registered counter, not derived from the pointers.
- Latency: a byte pushed at edge N appears on m_data with m_valid=1 after edge N (first-word fall-through; m_data = mem[rptr], read combinationally from registered storage). A pop at edge N exposes the next entry immediately after edge N.
- err_flag=1: err_cnt <= err_cnt+1, saturating at 2^ERR_W-1 with no wrap.
- clr_status=1: overflow<=0 and err_cnt<=0. If a set/increment event occurs in the same cycle, clear wins for that cycle.
- FIFO state is owned by rx_arst_n and rx_rst only. RX FSM reset mid-frame has no effect here, because only complete done_flag pulses push.
- Flags are not required to be pulses; each cycle done_flag=1 is treated as an independent push request.

Decomposition:
- Shared package / header: DATA_W default, DEPTH default, the clog2 helper for ADDR_W.
- One natural sub-module: rx_fifo_mem, a DEPTH x DATA_W register array with one write port and one asynchronous read port.
- Pointer, level, flag and counter logic stay in rx_byte_fifo.

Test Plan:
1. Reset, then push 0xA5 via done_flag -> after the next edge m_valid=1, m_data=0xA5, level=1. Pop with m_ready=1 -> m_valid=0, level=0.
2. Push 8 bytes 0x01..0x08 with m_ready=0 -> full=1, level=8. Push a 9th byte 0xFF -> dropped, overflow=1. Drain -> bytes come out as 0x01..0x08 in order.
3. While full, pulse done_flag (byte 0x55) and m_ready in the same cycle -> level stays 8, overflow stays 0, 0x55 is read last.
4. err_flag alone, then done_flag+err_flag together with rx_data=0x3C -> err_cnt=2, level unchanged, 0x3C never appears. 300 err pulses -> err_cnt=255. clr_status -> err_cnt=0, overflow=0.
5. Push 20 bytes with a continuous interleaved pop (pointer wrap exercised twice) -> output sequence equals input sequence, and full is never asserted.
6. With level=5, assert rx_rst together with a push and a pop -> next cycle level=0, m_valid=0, err_cnt=0. Assert rx_arst_n low mid-cycle -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rx_byte_fifo_pkg.sv
// Shared defaults and helpers for the UART RX byte FIFO.
package rx_byte_fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;
    localparam int ERR_W_DEF  = 8;

    // Constant-foldable ceil(log2(n)), used to derive pointer widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module rx_fifo_mem
    import rx_byte_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is intentionally not reset; contents are only read while valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through byte FIFO between the UART RX FSM/SIPO and the host,
// with sticky overflow and a saturating framing-error counter.
module rx_byte_fifo
    import rx_byte_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ERR_W  = ERR_W_DEF,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rx_arst_n,
    input  logic              rx_rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              done_flag,
    input  logic              err_flag,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [ERR_W-1:0]  err_cnt,
    input  logic              clr_status
);

    // Handshake: m_data is transferred on every rising edge where
    // m_valid && m_ready; m_valid never depends on m_ready, and m_ready
    // while m_valid=0 has no effect.

    logic [ADDR_W:0]    wptr_q;
    logic [ADDR_W:0]    rptr_q;
    logic [ADDR_W:0]    level_q;
    logic               overflow_q;
    logic [ERR_W-1:0]   err_cnt_q;

    logic empty;
    logic full_int;
    logic pop;
    logic push_req;
    logic push;
    logic drop;

    assign empty    = (wptr_q == rptr_q);
    assign full_int = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                      (wptr_q[ADDR_W] != rptr_q[ADDR_W]);

    assign pop      = ~empty & m_ready;
    // A frame flagged as a framing error is never stored, even if done_flag is also high.
    assign push_req = done_flag & ~err_flag;
    assign push     = push_req & (~full_int | pop);
    assign drop     = push_req & full_int & ~pop;

    rx_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_q[ADDR_W-1:0]),
        .wdata (rx_data),
        .raddr (rptr_q[ADDR_W-1:0]),
        .rdata (m_data)
    );

    always_ff @(posedge clk or negedge rx_arst_n) begin
        if (!rx_arst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (rx_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // Status registers: clr_status beats any same-cycle set or increment.
    always_ff @(posedge clk or negedge rx_arst_n) begin
        if (!rx_arst_n) begin
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else if (rx_rst || clr_status) begin
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (err_flag && (err_cnt_q != {ERR_W{1'b1}})) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign m_valid  = ~empty;
    assign full     = full_int;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed bench for rx_byte_fifo: push/pop ordering, full/overflow, error counting, resets.
module tb_rx_byte_fifo;

    logic       clk;
    logic       rx_arst_n;
    logic       rx_rst;
    logic [7:0] rx_data;
    logic       done_flag;
    logic       err_flag;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       full;
    logic [3:0] level;
    logic       overflow;
    logic [7:0] err_cnt;
    logic       clr_status;

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    rx_byte_fifo dut (
        .clk        (clk),
        .rx_arst_n  (rx_arst_n),
        .rx_rst     (rx_rst),
        .rx_data    (rx_data),
        .done_flag  (done_flag),
        .err_flag   (err_flag),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .full       (full),
        .level      (level),
        .overflow   (overflow),
        .err_cnt    (err_cnt),
        .clr_status (clr_status)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic push_byte(input logic [7:0] b);
        rx_data   = b;
        done_flag = 1'b1;
        step();
        done_flag = 1'b0;
    endtask

    task automatic err_pulse();
        err_flag = 1'b1;
        step();
        err_flag = 1'b0;
    endtask

    // Pop one entry, checking it against the scoreboard head first.
    task automatic pop_check(input string tag);
        check({tag, "_valid"}, m_valid, 1'b1);
        if (exp_q.size() > 0) begin
            check({tag, "_data"}, m_data, exp_q[0]);
            void'(exp_q.pop_front());
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rx_arst_n  = 1'b0;
        rx_rst     = 1'b0;
        rx_data    = 8'h00;
        done_flag  = 1'b0;
        err_flag   = 1'b0;
        m_ready    = 1'b0;
        clr_status = 1'b0;

        #12;
        check("rst_valid", m_valid, 1'b0);
        check("rst_level", level, 4'd0);
        check("rst_full", full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_err", err_cnt, 8'd0);
        rx_arst_n = 1'b1;
        step();

        // 1: single byte, fall-through, then pop
        push_byte(8'hA5);
        check("t1_valid", m_valid, 1'b1);
        check("t1_data", m_data, 8'hA5);
        check("t1_level", level, 4'd1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("t1_empty", m_valid, 1'b0);
        check("t1_level0", level, 4'd0);

        // 2: fill, overflow drop
        for (int i = 1; i <= 8; i++) begin
            push_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        check("t2_full", full, 1'b1);
        check("t2_level", level, 4'd8);
        check("t2_ovf0", overflow, 1'b0);
        push_byte(8'hFF);
        check("t2_ovf1", overflow, 1'b1);
        check("t2_level_drop", level, 4'd8);
        check("t2_head", m_data, 8'h01);

        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("t2_clr_ovf", overflow, 1'b0);

        // 3: push and pop together while full
        check("t3_head", m_data, exp_q[0]);
        void'(exp_q.pop_front());
        rx_data   = 8'h55;
        done_flag = 1'b1;
        m_ready   = 1'b1;
        step();
        done_flag = 1'b0;
        m_ready   = 1'b0;
        exp_q.push_back(8'h55);
        check("t3_level", level, 4'd8);
        check("t3_full", full, 1'b1);
        check("t3_ovf", overflow, 1'b0);
        for (int i = 0; i < 8; i++) begin
            pop_check("t3_drain");
        end
        check("t3_empty", m_valid, 1'b0);
        check("t3_level0", level, 4'd0);

        // 4: error counting, error wins over done, saturation, clear
        err_pulse();
        check("t4_err1", err_cnt, 8'd1);
        rx_data   = 8'h3C;
        done_flag = 1'b1;
        err_flag  = 1'b1;
        step();
        done_flag = 1'b0;
        err_flag  = 1'b0;
        check("t4_err2", err_cnt, 8'd2);
        check("t4_level", level, 4'd0);
        check("t4_nopush", m_valid, 1'b0);
        err_flag = 1'b1;
        for (int i = 0; i < 253; i++) begin
            step();
        end
        check("t4_err255", err_cnt, 8'd255);
        for (int i = 0; i < 47; i++) begin
            step();
        end
        check("t4_sat", err_cnt, 8'd255);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        err_flag   = 1'b0;
        check("t4_clr_wins", err_cnt, 8'd0);
        check("t4_clr_ovf", overflow, 1'b0);

        // 5: streaming with continuous pop, pointers wrap
        m_ready   = 1'b1;
        done_flag = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rx_data = 8'(8'h40 + i);
            if (exp_q.size() > 0) begin
                check("t5_data", m_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
            exp_q.push_back(8'(8'h40 + i));
            step();
            check("t5_nofull", full, 1'b0);
            check("t5_level", level, 4'd1);
        end
        done_flag = 1'b0;
        m_ready   = 1'b0;
        pop_check("t5_last");
        check("t5_empty", m_valid, 1'b0);

        // 6: synchronous clear overrides push/pop
        for (int i = 0; i < 5; i++) begin
            push_byte(8'(8'hC0 + i));
        end
        err_pulse();
        check("t6_level5", level, 4'd5);
        check("t6_err1", err_cnt, 8'd1);
        rx_rst    = 1'b1;
        done_flag = 1'b1;
        m_ready   = 1'b1;
        rx_data   = 8'h77;
        step();
        rx_rst    = 1'b0;
        done_flag = 1'b0;
        m_ready   = 1'b0;
        exp_q.delete();
        check("t6_srst_level", level, 4'd0);
        check("t6_srst_valid", m_valid, 1'b0);
        check("t6_srst_err", err_cnt, 8'd0);

        // asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) begin
            push_byte(8'(8'hD0 + i));
        end
        err_pulse();
        check("t6_level3", level, 4'd3);
        #2;
        rx_arst_n = 1'b0;
        #1;
        check("t6_arst_level", level, 4'd0);
        check("t6_arst_valid", m_valid, 1'b0);
        check("t6_arst_err", err_cnt, 8'd0);
        #3;
        rx_arst_n = 1'b1;
        step();
        check("t6_post_valid", m_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
